// File: rtl/tour_pkg.sv
// Shared constants and types for the tour command arbiter.
package tour_pkg;

    // Command opcodes in cmd[15:12]
    localparam logic [3:0] OPC_CAL     = 4'h2;
    localparam logic [3:0] OPC_MOVE    = 4'h4;
    localparam logic [3:0] OPC_FANFARE = 4'h5;

    // Headings in cmd[11:4]
    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    // Response bytes returned to the remote host
    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_POS = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        UART,
        T_VERT,
        T_VWAIT,
        T_HORZ,
        T_HWAIT
    } state_t;

endpackage

// File: rtl/move_decode.sv
// Splits a one-hot knight move into a vertical leg and a horizontal leg.
// The lowest set bit wins, so multi-hot inputs still decode deterministically.
module move_decode
    import tour_pkg::*;
(
    input  logic [7:0] move,
    output logic [7:0] vert_hdg,
    output logic [3:0] vert_sq,
    output logic [7:0] horz_hdg,
    output logic [3:0] horz_sq,
    output logic       valid
);

    // Priority decode of the move byte into heading/distance per leg
    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        vert_hdg = HDG_N;
        vert_sq  = 4'd0;
        horz_hdg = HDG_E;
        horz_sq  = 4'd0;
        valid    = 1'b1;
        casez (move)
            8'b???????1: begin vert_hdg = HDG_N; vert_sq = 4'd2; horz_hdg = HDG_E; horz_sq = 4'd1; end
            8'b??????10: begin vert_hdg = HDG_N; vert_sq = 4'd2; horz_hdg = HDG_W; horz_sq = 4'd1; end
            8'b?????100: begin vert_hdg = HDG_N; vert_sq = 4'd1; horz_hdg = HDG_W; horz_sq = 4'd2; end
            8'b????1000: begin vert_hdg = HDG_S; vert_sq = 4'd1; horz_hdg = HDG_W; horz_sq = 4'd2; end
            8'b???10000: begin vert_hdg = HDG_S; vert_sq = 4'd2; horz_hdg = HDG_W; horz_sq = 4'd1; end
            8'b??100000: begin vert_hdg = HDG_S; vert_sq = 4'd2; horz_hdg = HDG_E; horz_sq = 4'd1; end
            8'b?1000000: begin vert_hdg = HDG_S; vert_sq = 4'd1; horz_hdg = HDG_E; horz_sq = 4'd2; end
            8'b10000000: begin vert_hdg = HDG_N; vert_sq = 4'd1; horz_hdg = HDG_E; horz_sq = 4'd2; end
            default:     valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/tour_cmd_arbiter.sv
// Arbitrates the cmd_proc command bus between remote UART commands and the
// autonomous tour replay, which issues each knight move as two straight legs.
module tour_cmd_arbiter
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    input  logic        tour_go,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_done,
    output logic        tour_abort
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    state_t      state, state_nxt;
    logic        leg_sent;     // current leg has been presented, waiting for clr_cmd_rdy
    logic [15:0] cmd_q;
    logic        cmd_rdy_q;
    logic [7:0]  resp_q;
    logic [7:0]  horz_hdg_q;   // horizontal leg captured together with the vertical one
    logic [3:0]  horz_sq_q;

    logic [7:0]  vert_hdg, horz_hdg;
    logic [3:0]  vert_sq, horz_sq;
    logic        move_valid;
    logic        last_move;
    logic        in_leg;
    logic        leg_taken;

    move_decode u_move_decode (
        .move     (move),
        .vert_hdg (vert_hdg),
        .vert_sq  (vert_sq),
        .horz_hdg (horz_hdg),
        .horz_sq  (horz_sq),
        .valid    (move_valid)
    );

    assign last_move = (mv_indx == LAST_IDX);
    assign in_leg    = (state == T_VERT) || (state == T_HORZ);
    assign leg_taken = in_leg && leg_sent && clr_cmd_rdy;

    // State, leg datapath and pulse registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state      <= IDLE;
            leg_sent   <= 1'b0;
            cmd_q      <= 16'h0000;
            cmd_rdy_q  <= 1'b0;
            resp_q     <= RESP_ACK;
            mv_indx    <= 5'd0;
            horz_hdg_q <= HDG_N;
            horz_sq_q  <= 4'd0;
            tour_done  <= 1'b0;
            tour_abort <= 1'b0;
        end else begin
            state      <= state_nxt;
            resp_q     <= resp;
            tour_done  <= 1'b0;
            tour_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (tour_go) mv_indx <= 5'd0;
                end
                T_VERT: begin
                    if (!leg_sent) begin
                        if (move_valid) begin
                            cmd_q      <= {OPC_MOVE, vert_hdg, vert_sq};
                            cmd_rdy_q  <= 1'b1;
                            leg_sent   <= 1'b1;
                            horz_hdg_q <= horz_hdg;
                            horz_sq_q  <= horz_sq;
                        end else begin
                            tour_abort <= 1'b1;
                        end
                    end else if (clr_cmd_rdy) begin
                        cmd_rdy_q <= 1'b0;
                        leg_sent  <= 1'b0;
                    end
                end
                T_HORZ: begin
                    if (!leg_sent) begin
                        cmd_q     <= {OPC_FANFARE, horz_hdg_q, horz_sq_q};
                        cmd_rdy_q <= 1'b1;
                        leg_sent  <= 1'b1;
                    end else if (clr_cmd_rdy) begin
                        cmd_rdy_q <= 1'b0;
                        leg_sent  <= 1'b0;
                    end
                end
                T_HWAIT: begin
                    if (send_resp) begin
                        if (last_move) tour_done <= 1'b1;
                        else           mv_indx   <= mv_indx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state selection; tour_go has priority over a pending UART command
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tour_go) state_nxt = T_VERT;
                     else if (cmd_rdy_UART) state_nxt = UART;
            UART:    if (send_resp) state_nxt = IDLE;
            T_VERT:  if (!leg_sent && !move_valid) state_nxt = IDLE;
                     else if (leg_taken) state_nxt = T_VWAIT;
            T_VWAIT: if (send_resp) state_nxt = T_HORZ;
            T_HORZ:  if (leg_taken) state_nxt = T_HWAIT;
            T_HWAIT: if (send_resp) state_nxt = last_move ? IDLE : T_VERT;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus ownership muxing and response byte selection
    always_comb begin
        cmd              = cmd_q;
        cmd_rdy          = cmd_rdy_q;
        clr_cmd_rdy_UART = 1'b0;
        resp             = resp_q;
        case (state)
            UART: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_ACK;
            end
            T_VERT:  resp = RESP_POS;
            T_HORZ:  resp = last_move ? RESP_ACK : RESP_POS;
            default: ;
        endcase
    end

endmodule
